// File: rtl/mau_pkg.sv
// Shared encodings and helpers for the memory-stage load/store unit.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Reserved size code is folded into the misaligned abort path.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic m;
    m = 1'b0;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = a[0];
      SZ_WORD: m = (a != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load lane select plus sign/zero extension of the returned memory word.
module mem_access_unit_load_align
  import mau_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  a_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    shifted = rdata_i >> {a_i, 3'b000};
    b       = shifted[7:0];
    h       = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = uns_i ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: data_o = uns_i ? {16'h0, h} : {{16{h[15]}}, h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: alignment check, lane steering, req/ack to data memory.
// Optional ack timeout with bus error is enabled by defining MAU_TIMEOUT_EN.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_we,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [DATA_W-1:0] i_eff_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_misaligned,
  output logic              o_bus_err
);

  state_e      state_q;
  logic        we_q, uns_q, mis_q, berr_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [31:0] steer_d, ld_data;
  logic        acc_mis_d;
`ifdef MAU_TIMEOUT_EN
  logic [4:0]  cnt_q;
`endif

  always_comb begin
    acc_mis_d = is_misaligned(i_size, i_eff_addr[1:0]);
    case (i_size)
      SZ_BYTE: steer_d = {4{i_wdata[7:0]}};
      SZ_HALF: steer_d = {2{i_wdata[15:0]}};
      default: steer_d = i_wdata;
    endcase
  end

  mem_access_unit_load_align u_align (
    .rdata_i (i_mem_rdata),
    .a_i     (off_q),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .data_o  (ld_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= 4'b0000;
`ifdef MAU_TIMEOUT_EN
      cnt_q   <= 5'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (i_valid) begin
          we_q    <= i_we;
          uns_q   <= i_unsigned;
          size_q  <= i_size;
          off_q   <= i_eff_addr[1:0];
          addr_q  <= {i_eff_addr[31:2], 2'b00};
          be_q    <= acc_mis_d ? 4'b0000 : be_for(i_size, i_eff_addr[1:0]);
          wdata_q <= i_we ? steer_d : '0;
          mis_q   <= acc_mis_d;
          berr_q  <= 1'b0;
          state_q <= acc_mis_d ? ST_DONE : ST_REQ;
`ifdef MAU_TIMEOUT_EN
          cnt_q   <= 5'd0;
`endif
        end
        ST_REQ: begin
          if (i_mem_ack) begin
            if (!we_q) rdata_q <= ld_data;
            state_q <= ST_DONE;
          end
`ifdef MAU_TIMEOUT_EN
          else if (cnt_q == 5'(TIMEOUT_CYCLES - 1)) begin
            berr_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
`endif
        end
        ST_DONE: begin
          mis_q   <= 1'b0;
          berr_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ready      = (state_q == ST_IDLE);
  assign o_mem_req    = (state_q == ST_REQ);
  assign o_done       = (state_q == ST_DONE);
  assign o_mem_we     = we_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_be     = be_q;
  assign o_mem_wdata  = wdata_q;
  assign o_rdata      = rdata_q;
  assign o_misaligned = mis_q;
  assign o_bus_err    = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed test of mem_access_unit: stores, loads, misaligned aborts, stalls, reset, timeout.
module tb_mem_access_unit;

  logic        clk = 1'b0, rst = 1'b1;
  logic        valid = 1'b0, we = 1'b0, uns = 1'b0, ack = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] eff = '0, wd = '0, mrd = '0;
  logic        ready, mreq, mwe, done, mis, berr;
  logic [31:0] maddr, mwd, rdat;
  logic [3:0]  mbe;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_we(we), .i_size(size), .i_unsigned(uns), .i_eff_addr(eff), .i_wdata(wd),
    .o_mem_req(mreq), .o_mem_we(mwe), .o_mem_addr(maddr), .o_mem_be(mbe),
    .o_mem_wdata(mwd), .i_mem_ack(ack), .i_mem_rdata(mrd),
    .o_done(done), .o_rdata(rdat), .o_misaligned(mis), .o_bus_err(berr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic [1:0] s, input logic u,
                     input logic [31:0] a, input logic [31:0] d);
    valid = 1'b1; we = w; size = s; uns = u; eff = a; wd = d;
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_req",   32'(mreq),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_rdata", rdat,       32'h0);
    chk("rst_be",    32'(mbe),   32'h0);
    rst = 1'b0;

    // ack while idle is ignored
    ack = 1'b1; tick(); tick();
    chk("idle_ack_done", 32'(done), 32'd0);
    chk("idle_ack_rdy",  32'(ready), 32'd1);
    ack = 1'b0;

    // SB 0xA5 @0x1003
    req(1'b1, 2'b00, 1'b0, 32'h1003, 32'h0000_00A5);
    tick(); valid = 1'b0;
    chk("sb_req",   32'(mreq), 32'd1);
    chk("sb_we",    32'(mwe),  32'd1);
    chk("sb_ready", 32'(ready), 32'd0);
    chk("sb_addr",  maddr,     32'h1000);
    chk("sb_be",    32'(mbe),  32'b1000);
    chk("sb_wdata", mwd,       32'hA5A5A5A5);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("sb_done",  32'(done), 32'd1);
    chk("sb_mis",   32'(mis),  32'd0);
    chk("sb_rdy0",  32'(ready), 32'd0);
    chk("sb_req0",  32'(mreq), 32'd0);
    tick();
    chk("sb_idle",  32'(ready), 32'd1);
    chk("sb_done0", 32'(done), 32'd0);

    // SH 0xBEEF @0x6002
    req(1'b1, 2'b01, 1'b0, 32'h6002, 32'h1234_BEEF);
    tick(); valid = 1'b0;
    chk("sh_be",    32'(mbe), 32'b1100);
    chk("sh_wdata", mwd,      32'hBEEFBEEF);
    ack = 1'b1; tick(); ack = 1'b0; tick();

    // LH / LHU @0x2002
    req(1'b0, 2'b01, 1'b0, 32'h2002, 32'hFFFF_FFFF);
    tick(); valid = 1'b0;
    chk("lh_be",    32'(mbe), 32'b1100);
    chk("lh_wdata", mwd,      32'h0);
    chk("lh_we",    32'(mwe), 32'd0);
    ack = 1'b1; mrd = 32'h80017FFF; tick(); ack = 1'b0; mrd = '0;
    chk("lh_done",  32'(done), 32'd1);
    chk("lh_rdata", rdat,     32'hFFFF8001);
    tick();
    req(1'b0, 2'b01, 1'b1, 32'h2002, 32'h0);
    tick(); valid = 1'b0;
    ack = 1'b1; mrd = 32'h80017FFF; tick(); ack = 1'b0; mrd = '0;
    chk("lhu_rdata", rdat, 32'h00008001);
    tick();

    // LB @0x5001 and LBU @0x5000
    req(1'b0, 2'b00, 1'b0, 32'h5001, 32'h0);
    tick(); valid = 1'b0;
    chk("lb_be", 32'(mbe), 32'b0010);
    ack = 1'b1; mrd = 32'h12348056; tick(); ack = 1'b0;
    chk("lb_rdata", rdat, 32'hFFFFFF80);
    tick();
    req(1'b0, 2'b00, 1'b1, 32'h5000, 32'h0);
    tick(); valid = 1'b0;
    ack = 1'b1; mrd = 32'h12348056; tick(); ack = 1'b0; mrd = '0;
    chk("lbu_rdata", rdat, 32'h00000056);
    tick();

    // LW @0x3001 misaligned: immediate done, no request, rdata kept
    req(1'b0, 2'b10, 1'b0, 32'h3001, 32'h0);
    tick(); valid = 1'b0;
    chk("lwm_req",   32'(mreq), 32'd0);
    chk("lwm_done",  32'(done), 32'd1);
    chk("lwm_mis",   32'(mis),  32'd1);
    chk("lwm_rdata", rdat,      32'h00000056);
    tick();
    chk("lwm_idle",  32'(ready), 32'd1);
    chk("lwm_mis0",  32'(mis),   32'd0);

    // reserved size aborts as misaligned
    req(1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
    tick(); valid = 1'b0;
    chk("rsv_mis", 32'(mis),  32'd1);
    chk("rsv_req", 32'(mreq), 32'd0);
    tick();

    // LW @0x4000 with 5 wait cycles; inputs ignored while busy
    req(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0);
    tick();
    req(1'b1, 2'b00, 1'b0, 32'h9999, 32'h77);
    for (int i = 0; i < 5; i++) begin
      chk("lw_wait_req", 32'(mreq), 32'd1);
      chk("lw_wait_rdy", 32'(ready), 32'd0);
      tick();
    end
    chk("lw_last_req", 32'(mreq), 32'd1);
    chk("lw_hold_addr", maddr,    32'h4000);
    chk("lw_hold_we",   32'(mwe), 32'd0);
    ack = 1'b1; mrd = 32'hCAFEF00D; tick(); ack = 1'b0; mrd = '0; valid = 1'b0;
    chk("lw_done",  32'(done), 32'd1);
    chk("lw_rdata", rdat,      32'hCAFEF00D);
    chk("lw_berr",  32'(berr), 32'd0);
    tick();
    chk("lw_idle",  32'(ready), 32'd1);

    // reset in REQ, then immediate SW
    req(1'b0, 2'b10, 1'b0, 32'h7000, 32'h0);
    tick(); valid = 1'b0;
    chk("rr_req1", 32'(mreq), 32'd1);
    rst = 1'b1; tick();
    chk("rr_req0", 32'(mreq),  32'd0);
    chk("rr_rdy",  32'(ready), 32'd1);
    chk("rr_done", 32'(done),  32'd0);
    rst = 1'b0;
    req(1'b1, 2'b10, 1'b0, 32'h8004, 32'hDEADBEEF);
    tick(); valid = 1'b0;
    chk("sw_req",   32'(mreq), 32'd1);
    chk("sw_be",    32'(mbe),  32'b1111);
    chk("sw_addr",  maddr,     32'h8004);
    chk("sw_wdata", mwd,       32'hDEADBEEF);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("sw_done",  32'(done), 32'd1);
    tick();

`ifdef MAU_TIMEOUT_EN
    // no ack: request held 16 cycles, then bus error
    mrd = 32'h11111111;
    req(1'b0, 2'b10, 1'b0, 32'hA000, 32'h0);
    tick(); valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to_req", 32'(mreq), 32'd1);
      tick();
    end
    chk("to_req0",  32'(mreq), 32'd0);
    chk("to_done",  32'(done), 32'd1);
    chk("to_berr",  32'(berr), 32'd1);
    chk("to_rdata", rdat,      32'h0);
    tick();
    chk("to_idle",  32'(ready), 32'd1);
`else
    // no ack: request stays up indefinitely
    req(1'b0, 2'b10, 1'b0, 32'hA000, 32'h0);
    tick(); valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("nto_req",  32'(mreq), 32'd1);
    chk("nto_done", 32'(done), 32'd0);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("nto_berr", 32'(berr), 32'd0);
    chk("nto_fin",  32'(done), 32'd1);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
